// File: rtl/register_file_2r1w.sv
// register_file_2r1w
//   Parametrised register file: one write port, two asynchronous read ports
//   (A, B), a tri-state bus driver fed from port A, optional write-to-read
//   bypass and a DEPTH-cycle clear sweep sequenced by a two-state FSM.
// Ports
//   CLK, RESET          clock (rising edge), asynchronous active-high reset
//   wr_en/addr/data     write request, index and data
//   rd_addr_a/rd_data_a read port A (combinational)
//   rd_addr_b/rd_data_b read port B (combinational)
//   bus_oe/bus_out      bus_out = rd_data_a when bus_oe, else high impedance
//   clr_start           single-cycle pulse that starts the clear sweep
//   busy                clear sweep in progress
//   wr_ack              write accepted this cycle (combinational)
//   dbg_regs            stored contents, reg i at [i*WIDTH +: WIDTH]
module register_file_2r1w #(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned DEPTH    = 8,
   parameter bit          ZERO_REG = 1'b1,
   parameter bit          BYPASS   = 1'b1,
   localparam int unsigned AW      = $clog2(DEPTH)
) (
   input  logic                   CLK,
   input  logic                   RESET,
   input  logic                   wr_en,
   input  logic [AW-1:0]          wr_addr,
   input  logic [WIDTH-1:0]       wr_data,
   input  logic [AW-1:0]          rd_addr_a,
   output logic [WIDTH-1:0]       rd_data_a,
   input  logic [AW-1:0]          rd_addr_b,
   output logic [WIDTH-1:0]       rd_data_b,
   input  logic                   bus_oe,
   output tri logic [WIDTH-1:0]   bus_out,
   input  logic                   clr_start,
   output logic                   busy,
   output logic                   wr_ack,
   output logic [DEPTH*WIDTH-1:0] dbg_regs
);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SWEEP = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [AW-1:0]    ptr_q, ptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];

   // Writes are only taken while idle; reg0 swallows writes when hardwired.
   assign wr_ack = wr_en && (state_q == ST_IDLE) && !(ZERO_REG && (wr_addr == '0));
   assign busy   = (state_q == ST_SWEEP);

   // State and sweep-pointer register
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
      end
   end

   // Next-state logic for the clear sweep
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      case (state_q)
         ST_IDLE: begin
            if (clr_start) begin
               state_d = ST_SWEEP;
               ptr_d   = '0;
            end
         end
         ST_SWEEP: begin
            ptr_d = ptr_q + AW'(1);
            if (ptr_q == AW'(DEPTH - 1)) begin
               state_d = ST_IDLE;
               ptr_d   = '0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            ptr_d   = '0;
         end
      endcase
   end

   // Storage: the sweep owns the array while active, otherwise the write port
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (state_q == ST_SWEEP) begin
         mem_q[ptr_q] <= '0;
      end else if (wr_ack) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   // Read ports; the bypass only fires on an accepted write, so never mid-sweep
   always_comb begin
      rd_data_a = mem_q[rd_addr_a];
      if (ZERO_REG && (rd_addr_a == '0)) begin
         rd_data_a = '0;
      end
      if (BYPASS && wr_ack && (wr_addr == rd_addr_a)) begin
         rd_data_a = wr_data;
      end
   end

   always_comb begin
      rd_data_b = mem_q[rd_addr_b];
      if (ZERO_REG && (rd_addr_b == '0)) begin
         rd_data_b = '0;
      end
      if (BYPASS && wr_ack && (wr_addr == rd_addr_b)) begin
         rd_data_b = wr_data;
      end
   end

   assign bus_out = bus_oe ? rd_data_a : 'z;

   // Debug view shows stored values only
   for (genvar g = 0; g < int'(DEPTH); g++) begin : g_dbg
      assign dbg_regs[g*WIDTH +: WIDTH] = mem_q[g];
   end

endmodule

// File: tb/tb_register_file_2r1w.sv
// tb_register_file_2r1w
//   Drives two register files with identical stimulus: one with bypass, one
//   without. Expected values come from an array-based model of the register
//   contents and a countdown for the clear sweep.
module tb_register_file_2r1w;

   localparam int unsigned W = 8;
   localparam int unsigned D = 8;

   logic         CLK;
   logic         RESET;
   logic         wr_en;
   logic [2:0]   wr_addr;
   logic [7:0]   wr_data;
   logic [2:0]   rd_addr_a;
   logic [2:0]   rd_addr_b;
   logic         bus_oe;
   logic         clr_start;

   logic [7:0]   rd_a, rd_b, rd_a_nb, rd_b_nb;
   wire  [7:0]   bus_w, bus_nb_w;
   logic         busy, busy_nb, ack, ack_nb;
   logic [63:0]  dbg, dbg_nb;

   int n_checks = 0;
   int n_pass   = 0;

   register_file_2r1w #(.WIDTH(W), .DEPTH(D), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut (
      .CLK(CLK), .RESET(RESET), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_addr_a(rd_addr_a), .rd_data_a(rd_a), .rd_addr_b(rd_addr_b), .rd_data_b(rd_b),
      .bus_oe(bus_oe), .bus_out(bus_w), .clr_start(clr_start), .busy(busy),
      .wr_ack(ack), .dbg_regs(dbg)
   );

   register_file_2r1w #(.WIDTH(W), .DEPTH(D), .ZERO_REG(1'b1), .BYPASS(1'b0)) dut_nb (
      .CLK(CLK), .RESET(RESET), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_addr_a(rd_addr_a), .rd_data_a(rd_a_nb), .rd_addr_b(rd_addr_b), .rd_data_b(rd_b_nb),
      .bus_oe(bus_oe), .bus_out(bus_nb_w), .clr_start(clr_start), .busy(busy_nb),
      .wr_ack(ack_nb), .dbg_regs(dbg_nb)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Reference model: register contents plus remaining sweep cycles
   int m_regs [8];
   int m_left;
   int m_ptr;

   function automatic bit m_accept();
      return wr_en && (m_left == 0) && (wr_addr != 3'd0);
   endfunction

   function automatic logic [7:0] m_read(input logic [2:0] a, input bit byp);
      if (byp && m_accept() && (a == wr_addr)) return wr_data;
      if (a == 3'd0) return 8'h00;
      return 8'(m_regs[a]);
   endfunction

   function automatic logic [63:0] m_dbg();
      logic [63:0] v;
      for (int i = 0; i < 8; i++) v[i*8 +: 8] = 8'(m_regs[i]);
      return v;
   endfunction

   task automatic m_reset();
      for (int i = 0; i < 8; i++) m_regs[i] = 0;
      m_left = 0;
      m_ptr  = 0;
   endtask

   // One clock edge: advance the model with the inputs in force at the edge
   task automatic step();
      @(posedge CLK);
      if (m_left > 0) begin
         m_regs[m_ptr] = 0;
         m_ptr++;
         m_left--;
      end else begin
         if (m_accept()) m_regs[wr_addr] = int'(wr_data);
         if (clr_start) begin
            m_left = 8;
            m_ptr  = 0;
         end
      end
      #1;
   endtask

   task automatic idle_inputs();
      wr_en = 1'b0; wr_addr = 3'd0; wr_data = 8'h00;
      rd_addr_a = 3'd0; rd_addr_b = 3'd0; bus_oe = 1'b0; clr_start = 1'b0;
   endtask

   task automatic do_write(input logic [2:0] a, input logic [7:0] d);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      step();
      wr_en = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      RESET = 1'b0;
      #2 RESET = 1'b1;
      m_reset();
      repeat (2) @(posedge CLK);
      #1 RESET = 1'b0;
      for (int i = 0; i < 8; i++) begin
         rd_addr_a = 3'(i);
         rd_addr_b = 3'(7 - i);
         #1;
         n_checks++;
         if (rd_a !== 8'h00 || rd_b !== 8'h00)
            $display("FAIL reset_read idx=%0d got a=%h b=%h want 00", i, rd_a, rd_b);
         else n_pass++;
      end
      n_checks++;
      if (busy !== 1'b0 || ack !== 1'b0)
         $display("FAIL reset_status got busy=%b ack=%b want 0 0", busy, ack);
      else n_pass++;
      n_checks++;
      if (dbg !== 64'h0) $display("FAIL reset_dbg got %h want 0", dbg);
      else n_pass++;
      n_checks++;
      if (!(bus_w === 8'hzz || bus_w === 8'h00))
         $display("FAIL reset_bus got %h want zz", bus_w);
      else n_pass++;
   endtask

   task automatic test_write_read();
      wr_en = 1'b1; wr_addr = 3'd3; wr_data = 8'hA5;
      @(negedge CLK);
      n_checks++;
      if (ack !== 1'b1) $display("FAIL wr_ack_r3 got %b want 1", ack);
      else n_pass++;
      step();
      wr_en = 1'b0; rd_addr_a = 3'd3; rd_addr_b = 3'd3; bus_oe = 1'b1;
      @(negedge CLK);
      n_checks++;
      if (rd_a !== 8'hA5 || rd_b !== 8'hA5 || bus_w !== 8'hA5)
         $display("FAIL read_r3 got a=%h b=%h bus=%h want a5", rd_a, rd_b, bus_w);
      else n_pass++;
      bus_oe = 1'b0;
      #1;
      n_checks++;
      if (!(bus_w === 8'hzz || bus_w === 8'h00))
         $display("FAIL bus_release got %h want zz", bus_w);
      else n_pass++;
      step();
   endtask

   task automatic test_bypass();
      logic [7:0] old;
      old = m_read(3'd5, 1'b0);
      wr_en = 1'b1; wr_addr = 3'd5; wr_data = 8'h3C;
      rd_addr_a = 3'd5; rd_addr_b = 3'd5;
      @(negedge CLK);
      n_checks++;
      if (rd_a !== 8'h3C || rd_b !== 8'h3C)
         $display("FAIL bypass_same_cycle got a=%h b=%h want 3c", rd_a, rd_b);
      else n_pass++;
      n_checks++;
      if (rd_a_nb !== old || rd_b_nb !== old)
         $display("FAIL nobypass_same_cycle got a=%h b=%h want %h", rd_a_nb, rd_b_nb, old);
      else n_pass++;
      step();
      wr_en = 1'b0;
      @(negedge CLK);
      n_checks++;
      if (rd_a_nb !== 8'h3C || rd_a !== 8'h3C)
         $display("FAIL after_write_r5 got nb=%h byp=%h want 3c", rd_a_nb, rd_a);
      else n_pass++;
      step();
   endtask

   task automatic test_zero_reg();
      wr_en = 1'b1; wr_addr = 3'd0; wr_data = 8'hFF;
      rd_addr_a = 3'd0; rd_addr_b = 3'd0;
      @(negedge CLK);
      n_checks++;
      if (ack !== 1'b0 || rd_a !== 8'h00 || rd_b !== 8'h00)
         $display("FAIL zero_reg_write got ack=%b a=%h b=%h want 0 00 00", ack, rd_a, rd_b);
      else n_pass++;
      step();
      wr_en = 1'b0;
      @(negedge CLK);
      n_checks++;
      if (dbg[7:0] !== 8'h00 || rd_a !== 8'h00)
         $display("FAIL zero_reg_after got dbg0=%h a=%h want 00", dbg[7:0], rd_a);
      else n_pass++;
      step();
   endtask

   task automatic test_sweep();
      int busy_cycles;
      for (int i = 1; i < 8; i++) do_write(3'(i), 8'(i * 17));
      n_checks++;
      if (dbg !== m_dbg()) $display("FAIL fill got %h want %h", dbg, m_dbg());
      else n_pass++;
      clr_start = 1'b1;
      step();
      clr_start = 1'b0;
      busy_cycles = 0;
      for (int c = 0; c < 8; c++) begin
         rd_addr_a = 3'd7;
         rd_addr_b = 3'(c);
         wr_en = (c == 2);
         wr_addr = 3'd7; wr_data = 8'h99;
         if (c == 1) clr_start = 1'b1;
         @(negedge CLK);
         if (busy === 1'b1) busy_cycles++;
         n_checks++;
         if (ack !== 1'b0 || rd_a !== m_read(3'd7, 1'b1) || rd_b !== m_read(3'(c), 1'b1))
            $display("FAIL sweep_c%0d got ack=%b a=%h b=%h want 0 %h %h", c, ack, rd_a, rd_b,
                     m_read(3'd7, 1'b1), m_read(3'(c), 1'b1));
         else n_pass++;
         n_checks++;
         if (dbg !== m_dbg()) $display("FAIL sweep_dbg_c%0d got %h want %h", c, dbg, m_dbg());
         else n_pass++;
         step();
         clr_start = 1'b0;
      end
      wr_en = 1'b0;
      @(negedge CLK);
      n_checks++;
      if (busy_cycles != 8 || busy !== 1'b0)
         $display("FAIL sweep_len got cycles=%0d busy_after=%b want 8 0", busy_cycles, busy);
      else n_pass++;
      n_checks++;
      if (dbg !== 64'h0) $display("FAIL sweep_clear got %h want 0", dbg);
      else n_pass++;
      step();
   endtask

   task automatic test_reset_mid_sweep();
      for (int i = 1; i < 8; i++) do_write(3'(i), 8'($urandom_range(1, 255)));
      clr_start = 1'b1;
      step();
      clr_start = 1'b0;
      repeat (3) step();
      RESET = 1'b1;
      m_reset();
      #1;
      n_checks++;
      if (busy !== 1'b0 || dbg !== 64'h0)
         $display("FAIL mid_sweep_reset got busy=%b dbg=%h want 0 0", busy, dbg);
      else n_pass++;
      @(posedge CLK);
      #1 RESET = 1'b0;
      wr_en = 1'b1; wr_addr = 3'd2; wr_data = 8'h5A; rd_addr_a = 3'd2;
      @(negedge CLK);
      n_checks++;
      if (ack !== 1'b1) $display("FAIL post_reset_ack got %b want 1", ack);
      else n_pass++;
      step();
      wr_en = 1'b0;
      @(negedge CLK);
      n_checks++;
      if (rd_a_nb !== 8'h5A) $display("FAIL post_reset_read got %h want 5a", rd_a_nb);
      else n_pass++;
      step();
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         wr_en     = ($urandom_range(0, 3) != 0);
         wr_addr   = 3'($urandom_range(0, 7));
         wr_data   = 8'($urandom_range(0, 255));
         rd_addr_a = ($urandom_range(0, 2) == 0) ? wr_addr : 3'($urandom_range(0, 7));
         rd_addr_b = ($urandom_range(0, 2) == 0) ? wr_addr : 3'($urandom_range(0, 7));
         bus_oe    = 1'($urandom_range(0, 1));
         clr_start = ($urandom_range(0, 39) == 0);
         @(negedge CLK);
         n_checks++;
         if (rd_a !== m_read(rd_addr_a, 1'b1) || rd_b !== m_read(rd_addr_b, 1'b1) ||
             rd_a_nb !== m_read(rd_addr_a, 1'b0) || rd_b_nb !== m_read(rd_addr_b, 1'b0))
            $display("FAIL rand_read n=%0d got %h %h %h %h want %h %h %h %h", n,
                     rd_a, rd_b, rd_a_nb, rd_b_nb,
                     m_read(rd_addr_a, 1'b1), m_read(rd_addr_b, 1'b1),
                     m_read(rd_addr_a, 1'b0), m_read(rd_addr_b, 1'b0));
         else n_pass++;
         n_checks++;
         if (ack !== m_accept() || busy !== (m_left > 0) || dbg !== m_dbg() ||
             (bus_oe && bus_w !== m_read(rd_addr_a, 1'b1)))
            $display("FAIL rand_status n=%0d got ack=%b busy=%b dbg=%h bus=%h want %b %b %h", n,
                     ack, busy, dbg, bus_w, m_accept(), (m_left > 0), m_dbg());
         else n_pass++;
         step();
      end
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_bypass();
      test_zero_reg();
      test_sweep();
      test_reset_mid_sweep();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
